// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and the frame parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_REQ       = 3'd2,
      S_BITS      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_FAIL      = 3'd6
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

   // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
   function automatic logic ps2_odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings one raw PS/2 line into the clk domain: 2-flop synchroniser, run-length
// filter and a registered one-cycle falling-edge strobe. Idle level is high.
module ps2_line_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic          fall_q;
   logic          fall_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Filter: the accepted level only flips after FILTER_LEN consecutive differing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
      fall_d = level_q & ~level_d;
   end

   // Synchroniser, filter and strobe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter using request-to-send. Define PS2_TX_RETRY_EN to
// retry a failed byte twice before reporting tx_error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 3150,
   parameter int TIMEOUT_CYCLES = 472500,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   ps2_tx_state_t  state_q, state_d;
   logic [7:0]     data_q, data_d;
   logic           parity_q, parity_d;
   logic [ICW-1:0] inh_cnt_q, inh_cnt_d;
   logic [TCW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]     bit_idx_q, bit_idx_d;
   logic           clk_oe_q, clk_oe_d;
   logic           dat_oe_q, dat_oe_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;

   logic           clk_level_s;
   logic           clk_fall_s;
   logic           dat_level_s;
   logic           dat_fall_unused;
   logic           accept_s;
   logic           timeout_s;
   logic           fail_s;
   logic           bit_val_s;
   logic           retries_left_s;

`ifdef PS2_TX_RETRY_EN
   logic [1:0]     retry_q, retry_d;
   assign retries_left_s = (retry_q != 2'd2);
`else
   assign retries_left_s = 1'b0;
`endif

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .level   (clk_level_s),
      .fall    (clk_fall_s)
   );

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_dat_in),
      .level   (dat_level_s),
      .fall    (dat_fall_unused)
   );

   assign accept_s  = tx_valid & ready_q;
   assign timeout_s = (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

   // Frame bit for the current index: data LSB first, then parity, then stop.
   always_comb begin
      if (bit_idx_q < 4'd8) begin
         bit_val_s = data_q[bit_idx_q[2:0]];
      end else if (bit_idx_q == 4'd8) begin
         bit_val_s = parity_q;
      end else begin
         bit_val_s = 1'b1;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      parity_d  = parity_q;
      inh_cnt_d = '0;
      to_cnt_d  = '0;
      bit_idx_d = bit_idx_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      fail_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (accept_s) begin
               data_d   = tx_data;
               parity_d = ps2_odd_parity(tx_data);
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = 2'd0;
`endif
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_INHIBIT: begin
            clk_oe_d  = 1'b1;
            bit_idx_d = 4'd0;
            inh_cnt_d = inh_cnt_q + ICW'(1);
            if (inh_cnt_q == ICW'(INHIBIT_CYCLES - 1)) begin
               clk_oe_d  = 1'b0;
               dat_oe_d  = 1'b1;
               inh_cnt_d = '0;
               state_d   = S_REQ;
            end else if (inh_cnt_q == ICW'(INHIBIT_CYCLES - 2)) begin
               dat_oe_d = 1'b1;
            end else begin
               dat_oe_d = 1'b0;
            end
         end
         // The first fall after release already places data[0].
         S_REQ, S_BITS: begin
            to_cnt_d = to_cnt_q + TCW'(1);
            if (timeout_s) begin
               fail_s = 1'b1;
            end else if (clk_fall_s) begin
               dat_oe_d  = ~bit_val_s;
               bit_idx_d = bit_idx_q + 4'd1;
               state_d   = (bit_idx_q == 4'd9) ? S_ACK : S_BITS;
            end else begin
               state_d = state_q;
            end
         end
         S_ACK: begin
            to_cnt_d = to_cnt_q + TCW'(1);
            if (timeout_s) begin
               fail_s = 1'b1;
            end else if (clk_fall_s) begin
               if (dat_level_s) begin
                  fail_s = 1'b1;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end else begin
               state_d = S_ACK;
            end
         end
         // tx_done is raised while still busy; the following cycle returns to IDLE.
         S_WAIT_IDLE: begin
            to_cnt_d = to_cnt_q + TCW'(1);
            if (done_q) begin
               state_d = S_IDLE;
            end else if (timeout_s) begin
               fail_s = 1'b1;
            end else if (clk_level_s && dat_level_s) begin
               done_d = 1'b1;
            end else begin
               state_d = S_WAIT_IDLE;
            end
         end
         S_FAIL: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (retries_left_s) begin
               clk_oe_d = 1'b1;
               state_d  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
               retry_d  = retry_q + 2'd1;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
      if (fail_s) begin
         state_d  = S_FAIL;
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         error_d  = ~retries_left_s;
      end else begin
         error_d  = 1'b0;
      end
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         data_q    <= 8'h00;
         parity_q  <= 1'b0;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         bit_idx_q <= 4'd0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= 2'd0;
`endif
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         bit_idx_q <= bit_idx_d;
         clk_oe_q  <= clk_oe_d;
         dat_oe_q  <= dat_oe_d;
         done_q    <= done_d;
         error_q   <= error_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
`ifdef PS2_TX_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign tx_ready   = ready_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = error_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule
